pipeline_hazard_scheduler: RTL and testbench

Central sequencing controller for the 5-stage scalar pipeline (fetch, decode, execute, memory, writeback).
- Tracks in-flight register writes in a per-register countdown scoreboard.
- Detects RAW hazards at decode and stalls fetch/decode while inserting bubbles into execute.
- Sequences flushes after PC redirects and after reset, covering the synchronous ROM's 1-cycle read latency.
- Drives the enable/flush pins of the PC register and the pipeline registers.

---
 rtl/pipeline_hazard_scheduler_pkg.sv | 23 ++
 rtl/pipeline_hazard_scheduler_scoreboard.sv | 64 ++++++
 rtl/pipeline_hazard_scheduler.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_scheduler_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM states,
// default producer latency and the instruction field layout.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam int DEFAULT_LATENCY = 3;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int RD_HI     = 11;
  localparam int RD_LO     = 8;
  localparam int RS2_HI    = 7;
  localparam int RS2_LO    = 4;
  localparam int RS1_HI    = 3;
  localparam int RS1_LO    = 0;

endpackage

// File: rtl/pipeline_hazard_scheduler_scoreboard.sv
// Per-register countdown scoreboard. A nonzero entry means the register has
// a write still travelling down the pipeline and must not be read at decode.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int REG_AW  = 4,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              load,
  input  logic [REG_AW-1:0] load_addr,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [NREGS-1:0]  busy_mask
);

  localparam int SB_W = $clog2(LATENCY + 1);
  localparam logic [SB_W-1:0] SB_LOAD = SB_W'(LATENCY);

  logic [SB_W-1:0] sb_q [NREGS];
  logic [SB_W-1:0] sb_d [NREGS];

  // Next count: a new issue reloads its entry, every other busy entry ticks down.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      sb_d[i] = sb_q[i];
      if (!freeze) begin
        if (load && (load_addr == REG_AW'(i))) begin
          sb_d[i] = SB_LOAD;
        end else if (sb_q[i] != '0) begin
          sb_d[i] = sb_q[i] - 1'b1;
        end
      end
    end
  end

  // Counter storage, cleared asynchronously so no stale hazards survive reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

  // Busy flags for the two decode read ports and the full mask.
  always_comb begin
    busy_a = (sb_q[rd_addr_a] != '0);
    busy_b = (sb_q[rd_addr_b] != '0);
    for (int i = 0; i < NREGS; i++) begin
      busy_mask[i] = (sb_q[i] != '0);
    end
  end

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// Central sequencing controller for the 5-stage pipeline: RAW stall
// detection, post-redirect / post-reset flushing, and global freeze.
module pipeline_hazard_scheduler
  import pipe_ctrl_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int REG_AW  = 4,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              dec_wre,
  input  logic              redirect,
  input  logic              ext_stall,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_en,
  output logic              de_flush,
  output logic              em_en,
  output logic              issue,
  output logic [NREGS-1:0]  busy_mask,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             busy_rs1, busy_rs2;
  logic             hazard;
  logic             sb_load;

  hazard_scoreboard #(
    .NREGS   (NREGS),
    .REG_AW  (REG_AW),
    .LATENCY (LATENCY)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .freeze    (ext_stall),
    .load      (sb_load),
    .load_addr (dec_rd),
    .rd_addr_a (dec_rs1),
    .rd_addr_b (dec_rs2),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2),
    .busy_mask (busy_mask)
  );

  // Hazard uses only the registered scoreboard, so an instruction never sees its own rd.
  always_comb begin
    hazard = dec_valid & ((dec_use_rs1 & busy_rs1) | (dec_use_rs2 & busy_rs2));
  end

  // Output decode and next-state: freeze beats redirect, redirect beats hazard, hazard beats issue.
  always_comb begin
    pc_en       = 1'b0;
    fd_en       = 1'b0;
    fd_flush    = 1'b0;
    de_en       = 1'b0;
    de_flush    = 1'b0;
    em_en       = 1'b0;
    issue       = 1'b0;
    sb_load     = 1'b0;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (!reset) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (ext_stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        INIT: begin
          pc_en    = 1'b1;
          fd_flush = 1'b1;
          de_flush = 1'b1;
          em_en    = 1'b1;
          state_d  = RUN;
        end
        FLUSH: begin
          pc_en    = 1'b1;
          fd_flush = 1'b1;
          de_flush = 1'b1;
          em_en    = 1'b1;
          state_d  = redirect ? FLUSH : RUN;
        end
        RUN, STALL: begin
          if (redirect) begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            fd_flush = 1'b1;
            de_en    = 1'b1;
            de_flush = 1'b1;
            em_en    = 1'b1;
            state_d  = FLUSH;
          end else if (hazard) begin
            de_en       = 1'b1;
            de_flush    = 1'b1;
            em_en       = 1'b1;
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
            state_d     = STALL;
          end else begin
            pc_en   = 1'b1;
            fd_en   = 1'b1;
            de_en   = 1'b1;
            em_en   = 1'b1;
            issue   = dec_valid;
            sb_load = dec_valid & dec_wre;
            state_d = RUN;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  // State and stall statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Self-checking bench for pipeline_hazard_scheduler: scripted vector table,
// hand-written reset/saturation sequences and a randomized run against a
// cycle-level model of the sequencing rules.
module tb_pipeline_hazard_scheduler;

  localparam int NREGS   = 16;
  localparam int REG_AW  = 4;
  localparam int LATENCY = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic dec_valid, dec_use_rs1, dec_use_rs2, dec_wre, redirect, ext_stall;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic pc_en, fd_en, fd_flush, de_en, de_flush, em_en, issue;
  logic [NREGS-1:0] busy_mask;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_scheduler #(
    .NREGS(NREGS), .REG_AW(REG_AW), .LATENCY(LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wre(dec_wre),
    .redirect(redirect), .ext_stall(ext_stall),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en),
    .de_flush(de_flush), .em_en(em_en), .issue(issue),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       valid;
    logic [3:0] rs1, rs2, rd;
    logic       u1, u2, wre, redir, ext;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        pc_en, issue, fd_flush, de_flush;
    logic [15:0] busy;
    logic [3:0]  scnt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 = just out of reset, 1 = running (stalled or not), 2 = flushing
  int m_mode;
  int m_sb [NREGS];
  int m_stall;

  logic e_pc, e_fd, e_fdf, e_de, e_def, e_em, e_iss, e_chk_en;
  logic [15:0] e_busy;
  logic [3:0]  e_scnt;

  vec_t tbl [21];

  function automatic stim_t mk(input logic v, input int r1, input int r2, input int rd,
                               input logic u1, input logic u2, input logic w,
                               input logic rdr, input logic ex);
    stim_t s;
    s.valid = v; s.rs1 = 4'(r1); s.rs2 = 4'(r2); s.rd = 4'(rd);
    s.u1 = u1; s.u2 = u2; s.wre = w; s.redir = rdr; s.ext = ex;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic pc, input logic iss,
                               input logic fdf, input logic def, input int busy, input int sc);
    vec_t v;
    v.s = s; v.pc_en = pc; v.issue = iss; v.fd_flush = fdf; v.de_flush = def;
    v.busy = 16'(busy); v.scnt = 4'(sc);
    return v;
  endfunction

  function automatic logic [15:0] modelBusy();
    logic [15:0] m;
    for (int i = 0; i < NREGS; i++) m[i] = (m_sb[i] > 0);
    return m;
  endfunction

  function automatic logic modelHazard(input stim_t s);
    return s.valid && ((s.u1 && m_sb[s.rs1] > 0) || (s.u2 && m_sb[s.rs2] > 0));
  endfunction

  task automatic modelClear();
    for (int i = 0; i < NREGS; i++) m_sb[i] = 0;
    m_stall = 0;
    m_mode  = 0;
  endtask

  task automatic modelEval(input stim_t s);
    logic haz;
    haz = modelHazard(s);
    e_busy = modelBusy();
    e_scnt = 4'(m_stall);
    e_pc = 0; e_fd = 0; e_fdf = 0; e_de = 0; e_def = 0; e_em = 0; e_iss = 0;
    e_chk_en = 1;
    if (s.ext) begin
      e_chk_en = 1;
    end else if (m_mode == 0 || m_mode == 2 || s.redir) begin
      e_pc = 1; e_fdf = 1; e_def = 1; e_chk_en = 0;
    end else if (haz) begin
      e_de = 1; e_def = 1; e_em = 1;
    end else begin
      e_pc = 1; e_fd = 1; e_de = 1; e_em = 1; e_iss = s.valid;
    end
  endtask

  task automatic modelAdvance(input stim_t s);
    logic haz, running, do_issue;
    if (s.ext) return;
    haz      = modelHazard(s);
    running  = (m_mode == 1) && !s.redir;
    do_issue = running && !haz && s.valid;
    if (running && haz && m_stall < CNT_MAX) m_stall++;
    for (int i = 0; i < NREGS; i++) if (m_sb[i] > 0) m_sb[i]--;
    if (do_issue && s.wre) m_sb[s.rd] = LATENCY;
    if (m_mode == 0)      m_mode = 1;
    else if (s.redir)     m_mode = 2;
    else                  m_mode = 1;
  endtask

  task automatic applyStimulus(input stim_t s);
    dec_valid = s.valid; dec_rs1 = s.rs1; dec_rs2 = s.rs2; dec_rd = s.rd;
    dec_use_rs1 = s.u1; dec_use_rs2 = s.u2; dec_wre = s.wre;
    redirect = s.redir; ext_stall = s.ext;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".pc_en"}, 32'(pc_en), 0);
    checkOutput({tag, ".fd_en"}, 32'(fd_en), 0);
    checkOutput({tag, ".de_en"}, 32'(de_en), 0);
    checkOutput({tag, ".em_en"}, 32'(em_en), 0);
    checkOutput({tag, ".issue"}, 32'(issue), 0);
    checkOutput({tag, ".fd_flush"}, 32'(fd_flush), 1);
    checkOutput({tag, ".de_flush"}, 32'(de_flush), 1);
    checkOutput({tag, ".busy_mask"}, 32'(busy_mask), 0);
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
  endtask

  // One clock: drive, compare mid-cycle against model (and table row if given), advance.
  task automatic runCycle(input stim_t s, input string tag, input logic use_vec, input vec_t v);
    applyStimulus(s);
    @(negedge clk);
    modelEval(s);
    checkOutput({tag, ".pc_en"}, 32'(pc_en), 32'(e_pc));
    checkOutput({tag, ".issue"}, 32'(issue), 32'(e_iss));
    checkOutput({tag, ".fd_flush"}, 32'(fd_flush), 32'(e_fdf));
    checkOutput({tag, ".de_flush"}, 32'(de_flush), 32'(e_def));
    checkOutput({tag, ".busy_mask"}, 32'(busy_mask), 32'(e_busy));
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e_scnt));
    if (e_chk_en) begin
      checkOutput({tag, ".fd_en"}, 32'(fd_en), 32'(e_fd));
      checkOutput({tag, ".de_en"}, 32'(de_en), 32'(e_de));
      checkOutput({tag, ".em_en"}, 32'(em_en), 32'(e_em));
    end
    if (use_vec) begin
      checkOutput({tag, ".tbl_pc_en"}, 32'(pc_en), 32'(v.pc_en));
      checkOutput({tag, ".tbl_issue"}, 32'(issue), 32'(v.issue));
      checkOutput({tag, ".tbl_fd_flush"}, 32'(fd_flush), 32'(v.fd_flush));
      checkOutput({tag, ".tbl_de_flush"}, 32'(de_flush), 32'(v.de_flush));
      checkOutput({tag, ".tbl_busy"}, 32'(busy_mask), 32'(v.busy));
      checkOutput({tag, ".tbl_stall_cnt"}, 32'(stall_cnt), 32'(v.scnt));
    end
    modelAdvance(s);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    modelClear();
    @(negedge clk);
    checkReset(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  dummy;
    stim_t s;
    string tag;

    dummy = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);

    tbl[0]  = mkv(mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 1, 0, 1, 1, 'h0, 0);
    tbl[1]  = mkv(mk(1, 0, 0, 2, 0, 0, 1, 0, 0), 1, 1, 0, 0, 'h0, 0);
    tbl[2]  = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1, 'h4, 0);
    tbl[3]  = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1, 'h4, 1);
    tbl[4]  = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1, 'h4, 2);
    tbl[5]  = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 0), 1, 1, 0, 0, 'h0, 3);
    tbl[6]  = mkv(mk(1, 0, 0, 2, 0, 0, 1, 0, 0), 1, 1, 0, 0, 'h0, 3);
    tbl[7]  = mkv(mk(1, 5, 6, 0, 1, 1, 0, 0, 0), 1, 1, 0, 0, 'h4, 3);
    tbl[8]  = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1, 'h4, 3);
    tbl[9]  = mkv(mk(1, 2, 0, 0, 1, 0, 0, 1, 0), 1, 0, 1, 1, 'h4, 4);
    tbl[10] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 1, 1, 'h0, 4);
    tbl[11] = mkv(mk(1, 0, 0, 2, 0, 0, 1, 0, 0), 1, 1, 0, 0, 'h0, 4);
    tbl[12] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 'h4, 4);
    tbl[13] = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 1), 0, 0, 0, 0, 'h4, 4);
    tbl[14] = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 1), 0, 0, 0, 0, 'h4, 4);
    tbl[15] = mkv(mk(1, 2, 0, 0, 1, 0, 0, 1, 1), 0, 0, 0, 0, 'h4, 4);
    tbl[16] = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 1), 0, 0, 0, 0, 'h4, 4);
    tbl[17] = mkv(mk(1, 2, 0, 0, 1, 0, 0, 0, 1), 0, 0, 0, 0, 'h4, 4);
    tbl[18] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 'h4, 4);
    tbl[19] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 'h4, 4);
    tbl[20] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 'h0, 4);

    $display("[TB] vector table");
    doReset("rst0");
    for (int i = 0; i < 21; i++) begin
      tag = $sformatf("vec%0d", i);
      runCycle(tbl[i].s, tag, 1'b1, tbl[i]);
    end

    $display("[TB] reset asserted mid-stall");
    runCycle(mk(1, 0, 0, 7, 0, 0, 1, 0, 0), "midrst_w", 1'b0, dummy);
    applyStimulus(mk(1, 7, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("midrst_pre.busy_mask", 32'(busy_mask), 32'h0080);
    checkOutput("midrst_pre.pc_en", 32'(pc_en), 0);
    #1;
    reset = 1'b0;
    modelClear();
    #1;
    checkReset("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    runCycle(mk(1, 0, 0, 3, 0, 0, 1, 0, 0), "midrst_init", 1'b0, dummy);
    runCycle(mk(1, 0, 0, 3, 0, 0, 1, 0, 0), "midrst_run", 1'b0, dummy);

    $display("[TB] stall counter saturation");
    doReset("rst_sat");
    for (int i = 0; i < 40; i++) begin
      runCycle(mk(1, 7, 0, 7, 1, 0, 1, 0, 0), "sat", 1'b0, dummy);
    end
    @(negedge clk);
    checkOutput("sat.stall_cnt_max", 32'(stall_cnt), CNT_MAX);

    $display("[TB] randomized run");
    doReset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      s.valid = ($urandom_range(0, 3) != 0);
      s.rs1   = 4'($urandom_range(0, 7));
      s.rs2   = 4'($urandom_range(0, 7));
      s.rd    = 4'($urandom_range(0, 7));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.wre   = 1'($urandom_range(0, 1));
      s.redir = ($urandom_range(0, 11) == 0);
      s.ext   = ($urandom_range(0, 9) == 0);
      runCycle(s, "rand", 1'b0, dummy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
